// File: rtl/seq_chk_pkg.sv
// Shared types for the a ##1 b ##1 c ##2 d sequence checker.
// Event records carry the attempt start stamp, the verdict and the offending signal.
// Stamp field width is fixed here; the top's STAMP_W must not exceed EVT_STAMP_W.
package seq_chk_pkg;

  localparam int EVT_STAMP_W = 16;
  localparam int N_STAGES    = 5;
  localparam int MAX_EVT     = 4;

  typedef enum logic [1:0] {
    CODE_A = 2'd0,
    CODE_B = 2'd1,
    CODE_C = 2'd2,
    CODE_D = 2'd3
  } sig_code_e;

  typedef struct packed {
    logic [EVT_STAMP_W-1:0] stamp;
    logic                   pass;
    sig_code_e              code;
  } evt_t;

endpackage

// File: rtl/seq_evt_fifo.sv
// Multi-write (up to MAX_EVT per cycle), single-read event FIFO with drop accounting.
// Latency: an entry written at edge E is at the head in the next cycle if the FIFO was empty.
// Backpressure: head holds while rd_rdy_i=0; excess writes beyond free space are dropped and counted.
module seq_evt_fifo
  import seq_chk_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               wr_n_i,
  input  evt_t                     wr_dat_i [MAX_EVT],
  output logic                     rd_vld_o,
  input  logic                     rd_rdy_i,
  output evt_t                     rd_dat_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ovf_o,
  output logic [7:0]               drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  evt_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            ovf_q;
  logic [7:0]      drop_cnt_q;

  logic            pop;
  logic [LW-1:0]   free, n_req, n_wr, n_drop;
  logic [8:0]      drop_sum;

  assign rd_vld_o   = (cnt_q != '0);
  assign rd_dat_o   = rd_vld_o ? mem[rd_ptr_q] : '0;
  assign level_o    = cnt_q;
  assign ovf_o      = ovf_q;
  assign drop_cnt_o = drop_cnt_q;

  // Free space includes the slot released by a same-cycle pop; writes beyond it are dropped.
  always_comb begin
    pop      = rd_vld_o & rd_rdy_i;
    free     = LW'(DEPTH) - cnt_q + LW'(pop);
    n_req    = LW'(wr_n_i);
    n_wr     = (n_req < free) ? n_req : free;
    n_drop   = n_req - n_wr;
    drop_sum = {1'b0, drop_cnt_q} + 9'(n_drop);
    cnt_d    = cnt_q + n_wr - LW'(pop);
  end

  // Pointers, occupancy and sticky drop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_q + AW'(n_wr);
      rd_ptr_q   <= rd_ptr_q + AW'(pop);
      cnt_q      <= cnt_d;
      if (n_drop != '0) ovf_q <= 1'b1;
      drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // Storage: the first n_wr request slots land in consecutive entries, oldest first.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_EVT; i++) begin
      if (LW'(i) < n_wr) mem[wr_ptr_q + AW'(i)] <= wr_dat_i[i];
    end
  end

endmodule

// File: rtl/seq_chk_ctrl.sv
// Concurrent checker for a ##1 b ##1 c ##2 d, one attempt per enabled cycle, verdicts queued.
// Latency: verdict decided at edge E is on evt_* in the next cycle when the queue was empty.
// Backpressure: evt_* held while evt_ready=0; verdicts that find no space are dropped and counted.
module seq_chk_ctrl
  import seq_chk_pkg::*;
#(
  parameter int STAMP_W     = 16,
  parameter int DEPTH       = 8,
  parameter int REPORT_PASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   a,
  input  logic                   b,
  input  logic                   c,
  input  logic                   d,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [STAMP_W-1:0]     evt_stamp,
  output logic                   evt_pass,
  output logic [1:0]             evt_code,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic [7:0]             drop_cnt
);

  // Age 0 is the attempt launched this cycle (en + current stamp); ages 1..4 are registered.
  logic [STAMP_W-1:0]          stamp_q;
  logic [N_STAGES-1:1]         live_q, live_d;
  logic [STAMP_W-1:0]          stg_q [1:N_STAGES-1];
  logic [STAMP_W-1:0]          stg_d [1:N_STAGES-1];
  logic [N_STAGES-1:0]         live;

  evt_t                        wdat [MAX_EVT];
  logic [2:0]                  n;
  evt_t                        head;

  assign live = {live_q, en};

  // Free-running stamp, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) stamp_q <= '0;
    else     stamp_q <= stamp_q + 1'b1;
  end

  // An attempt advances only if this age's check held; age 3 has no check, age 4 retires.
  always_comb begin
    live_d[1] = live[0] & a;
    live_d[2] = live[1] & b;
    live_d[3] = live[2] & c;
    live_d[4] = live[3];
    stg_d[1]  = stamp_q;
    stg_d[2]  = stg_q[1];
    stg_d[3]  = stg_q[2];
    stg_d[4]  = stg_q[3];
  end

  // Live bits are cleared by reset so in-flight attempts never report.
  always_ff @(posedge clk) begin
    if (rst) live_q <= '0;
    else     live_q <= live_d;
  end

  // Stamps need no reset: they are only observed alongside a live bit.
  always_ff @(posedge clk) begin
    stg_q <= stg_d;
  end

  // Pack this cycle's verdicts oldest attempt first: age4, age2, age1, age0.
  always_comb begin
    n = 3'd0;
    for (int i = 0; i < MAX_EVT; i++) wdat[i] = '0;
    if (live[4] && (!d || (REPORT_PASS != 0))) begin
      wdat[n[1:0]] = '{stamp: EVT_STAMP_W'(stg_q[4]), pass: d, code: CODE_D};
      n = n + 3'd1;
    end
    if (live[2] && !c) begin
      wdat[n[1:0]] = '{stamp: EVT_STAMP_W'(stg_q[2]), pass: 1'b0, code: CODE_C};
      n = n + 3'd1;
    end
    if (live[1] && !b) begin
      wdat[n[1:0]] = '{stamp: EVT_STAMP_W'(stg_q[1]), pass: 1'b0, code: CODE_B};
      n = n + 3'd1;
    end
    if (live[0] && !a) begin
      wdat[n[1:0]] = '{stamp: EVT_STAMP_W'(stamp_q), pass: 1'b0, code: CODE_A};
      n = n + 3'd1;
    end
  end

  seq_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_n_i     (n),
    .wr_dat_i   (wdat),
    .rd_vld_o   (evt_valid),
    .rd_rdy_i   (evt_ready),
    .rd_dat_o   (head),
    .level_o    (level),
    .ovf_o      (ovf),
    .drop_cnt_o (drop_cnt)
  );

  assign evt_stamp = head.stamp[STAMP_W-1:0];
  assign evt_pass  = head.pass;
  assign evt_code  = head.code;

endmodule

// File: tb/tb_seq_chk_ctrl.sv
// Self-checking bench for seq_chk_ctrl: directed scenarios plus randomized traffic.
// Reference model tracks attempts as (stamp, age) records and the FIFO as a bounded queue.
// Outputs are compared 1 time unit after every rising edge.
module tb_seq_chk_ctrl;

  localparam int STAMP_W     = 16;
  localparam int DEPTH       = 8;
  localparam int REPORT_PASS = 1;

  logic                   clk = 1'b0;
  logic                   rst, en, a, b, c, d, evt_ready;
  logic                   evt_valid, evt_pass, ovf;
  logic [STAMP_W-1:0]     evt_stamp;
  logic [1:0]             evt_code;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]             drop_cnt;

  seq_chk_ctrl #(.STAMP_W(STAMP_W), .DEPTH(DEPTH), .REPORT_PASS(REPORT_PASS)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .d(d),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_stamp(evt_stamp),
    .evt_pass(evt_pass), .evt_code(evt_code), .level(level), .ovf(ovf),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {int stamp; int age;} att_t;
  typedef struct {int stamp; bit pass; int code;} ev_t;

  att_t att[$];
  ev_t  mq[$];
  ev_t  popped[$];
  int   m_stamp = 0;
  int   m_drop  = 0;
  bit   m_ovf   = 0;

  int   exp_s [8];
  int   exp_p [8];
  int   exp_c [8];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the sequence rules to the values sampled at this edge.
  task automatic model_edge();
    ev_t  evs[$];
    att_t keep[$];
    bit   sig [5];
    if (rst) begin
      att.delete(); mq.delete();
      m_stamp = 0; m_drop = 0; m_ovf = 0;
      return;
    end
    if (en) att.push_back('{stamp: m_stamp, age: 0});
    sig[0] = a; sig[1] = b; sig[2] = c; sig[3] = 1'b1; sig[4] = d;
    // att is kept oldest first, so verdicts come out oldest first.
    foreach (att[i]) begin
      att_t x = att[i];
      if (!sig[x.age])
        evs.push_back('{stamp: x.stamp, pass: 1'b0, code: (x.age == 4) ? 3 : x.age});
      else if (x.age == 4) begin
        if (REPORT_PASS != 0) evs.push_back('{stamp: x.stamp, pass: 1'b1, code: 3});
      end else begin
        x.age++;
        keep.push_back(x);
      end
    end
    att = keep;
    if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
    foreach (evs[i]) begin
      if (mq.size() < DEPTH) mq.push_back(evs[i]);
      else begin
        m_ovf  = 1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
    end
    m_stamp = (m_stamp + 1) % (1 << STAMP_W);
  endtask

  task automatic compare_all();
    chk_eq("valid", 32'(evt_valid), 32'(mq.size() != 0));
    chk_eq("level", 32'(level), 32'(mq.size()));
    chk_eq("ovf", 32'(ovf), 32'(m_ovf));
    chk_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (mq.size() != 0) begin
      chk_eq("head_stamp", 32'(evt_stamp), 32'(mq[0].stamp));
      chk_eq("head_pass", 32'(evt_pass), 32'(mq[0].pass));
      chk_eq("head_code", 32'(evt_code), 32'(mq[0].code));
    end
  endtask

  task automatic step();
    if (evt_valid && evt_ready)
      popped.push_back('{stamp: int'(evt_stamp), pass: evt_pass, code: int'(evt_code)});
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1; en = 0; a = 0; b = 0; c = 0; d = 0; evt_ready = 0;
    step();
    rst = 0;
  endtask

  task automatic apply5(input logic [4:0] pa, input logic [4:0] pb,
                        input logic [4:0] pc, input logic [4:0] pd);
    for (int i = 0; i < 5; i++) begin
      en = 1; a = pa[i]; b = pb[i]; c = pc[i]; d = pd[i];
      step();
    end
    en = 0; a = 0; b = 0; c = 0; d = 0;
  endtask

  task automatic drain_chk(input string tag, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      chk_eq({tag, "_stamp"}, 32'(evt_stamp), 32'(exp_s[i]));
      chk_eq({tag, "_pass"}, 32'(evt_pass), 32'(exp_p[i]));
      chk_eq({tag, "_code"}, 32'(evt_code), 32'(exp_c[i]));
      evt_ready = 1;
      step();
      evt_ready = 0;
    end
    chk_eq({tag, "_empty"}, 32'(evt_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_a, n_p;
    rst = 1; en = 0; a = 0; b = 0; c = 0; d = 0; evt_ready = 0;

    // Reset state.
    do_reset();
    chk_eq("rst_valid", 32'(evt_valid), 32'd0);
    chk_eq("rst_stamp", 32'(evt_stamp), 32'd0);
    chk_eq("rst_pass", 32'(evt_pass), 32'd0);
    chk_eq("rst_code", 32'(evt_code), 32'd0);
    chk_eq("rst_level", 32'(level), 32'd0);
    chk_eq("rst_ovf", 32'(ovf), 32'd0);
    chk_eq("rst_drop", 32'(drop_cnt), 32'd0);

    // Basic pass: PASS for stamp 0 ordered ahead of FAIL A for stamp 4.
    apply5(5'b00001, 5'b00010, 5'b00100, 5'b10000);
    chk_eq("basic_level", 32'(level), 32'd5);
    exp_s = '{1, 2, 3, 0, 4, 0, 0, 0};
    exp_p = '{0, 0, 0, 1, 0, 0, 0, 0};
    exp_c = '{0, 0, 0, 3, 0, 0, 0, 0};
    drain_chk("basic", 5);

    // Quad event: four verdicts in one cycle, oldest first.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [4:0] pa, pb, pc;
      pa = 5'b01101; pb = 5'b01010; pc = 5'b00100;
      en = 1; a = pa[i]; b = pb[i]; c = pc[i]; d = 0;
      step();
    end
    chk_eq("quad_lvl_before", 32'(level), 32'd1);
    en = 1; a = 0; b = 0; c = 0; d = 0;
    step();
    en = 0;
    chk_eq("quad_lvl_after", 32'(level), 32'd5);
    exp_s = '{1, 0, 2, 3, 4, 0, 0, 0};
    exp_p = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_c = '{0, 3, 2, 1, 0, 0, 0, 0};
    drain_chk("quad", 5);

    // Overflow, same-cycle pop relief, then saturation.
    do_reset();
    en = 1; a = 0;
    repeat (DEPTH) step();
    chk_eq("ovf_full_level", 32'(level), 32'(DEPTH));
    chk_eq("ovf_not_yet", 32'(ovf), 32'd0);
    step();
    chk_eq("ovf_set", 32'(ovf), 32'd1);
    chk_eq("ovf_drop1", 32'(drop_cnt), 32'd1);
    chk_eq("ovf_head", 32'(evt_stamp), 32'd0);
    step();
    chk_eq("ovf_drop2", 32'(drop_cnt), 32'd2);
    evt_ready = 1;
    repeat (5) step();
    chk_eq("full_pop_nodrop", 32'(drop_cnt), 32'd2);
    chk_eq("full_pop_level", 32'(level), 32'(DEPTH));
    evt_ready = 0;
    repeat (260) step();
    chk_eq("drop_sat", 32'(drop_cnt), 32'd255);
    chk_eq("ovf_sticky", 32'(ovf), 32'd1);

    // Backpressure: ready toggles, dequeued stamps strictly increase.
    do_reset();
    popped.delete();
    for (int i = 0; i < 200; i++) begin
      evt_ready = i[0];
      en = ($urandom_range(0, 2) == 0);
      a = 0;
      step();
    end
    en = 0; evt_ready = 1;
    repeat (12) step();
    chk_eq("bp_some", 32'(popped.size() > 10), 32'd1);
    for (int i = 1; i < popped.size(); i++)
      chk_eq("bp_order", 32'(popped[i].stamp > popped[i-1].stamp), 32'd1);

    // en gating: no FAIL A while disabled, earlier attempts still complete.
    do_reset();
    popped.delete();
    evt_ready = 1;
    for (int i = 0; i < 16; i++) begin
      en = (i < 5); a = (i < 5); b = 1; c = 1; d = 1;
      step();
    end
    n_a = 0; n_p = 0;
    foreach (popped[i]) begin
      if (popped[i].code == 0 && popped[i].stamp >= 5 && popped[i].stamp <= 9) n_a++;
      if (popped[i].pass) n_p++;
    end
    chk_eq("en_gate_no_failA", 32'(n_a), 32'd0);
    chk_eq("en_gate_passes", 32'(n_p), 32'd5);

    // Reset mid-flight.
    do_reset();
    en = 1; a = 1; b = 0; c = 0; step();
    a = 0; b = 1; step();
    a = 1; b = 1; c = 1; step();
    chk_eq("mid_lvl_pre", 32'(level), 32'd1);
    rst = 1; step();
    rst = 0;
    chk_eq("mid_rst_level", 32'(level), 32'd0);
    chk_eq("mid_rst_valid", 32'(evt_valid), 32'd0);
    en = 1; a = 0; b = 0; c = 0; d = 0; step();
    chk_eq("mid_stamp0", 32'(evt_stamp), 32'd0);
    chk_eq("mid_code", 32'(evt_code), 32'd0);
    en = 0; evt_ready = 1;
    popped.delete();
    repeat (8) step();
    chk_eq("mid_only_one", 32'(popped.size()), 32'd1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 2500; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      en        = ($urandom_range(0, 3) != 0);
      a         = ($urandom_range(0, 3) != 0);
      b         = ($urandom_range(0, 3) != 0);
      c         = ($urandom_range(0, 3) != 0);
      d         = ($urandom_range(0, 3) != 0);
      evt_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_chk_ctrl.md
# seq_chk_ctrl

Synthesizable scheduler/checker for the four-signal handshake sequence a ##1 b ##1 c ##2 d: one attempt per enabled clock, every attempt tracked concurrently in a 5-stage age pipeline. Pass and fail verdicts are queued in a multi-write event FIFO, each tagged with the attempt's start stamp and the offending signal. The FIFO drains over a valid/ready port. Sits beside the datapath that drives a/b/c/d, as the hardware counterpart of the bench-level concurrent assertion.

## Interface
- STAMP_W, 16: width of the free-running cycle stamp.
- DEPTH, 8: event FIFO entries; power of two, ≥4.
- REPORT_PASS, 1: 1 = queue PASS events; 0 = queue FAIL events only.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = start a new attempt this cycle.
- a, b, c, d  in  1 each  monitored signals, sampled at posedge.
- evt_valid  out  1  head entry valid.
- evt_ready  in  1  consumer accepts head when evt_valid=1.
- evt_stamp  out  STAMP_W  start stamp of the reported attempt.
- evt_pass  out  1  1 = PASS, 0 = FAIL.
- evt_code  out  2  offending signal: 0=A, 1=B, 2=C, 3=D; PASS reports D.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- ovf  out  1  sticky; set on any dropped event; cleared only by rst.
- drop_cnt  out  8  dropped events, saturates at 255.

## Operation
- Stamp counter: 0 after rst, +1 every cycle regardless of en, wraps modulo 2^STAMP_W.
- Attempt pipeline: stages 0..4, each holding {live, stamp}. Stage k holds the attempt of age k. When en=1, stage 0 loads live=1 and the current stamp. Live attempts advance one stage per cycle whether en is 0 or 1.
- Checks per stage, same cycle:
  - age0: a=0 → FAIL A
  - age1: b=0 → FAIL B
  - age2: c=0 → FAIL C
  - age3: no check
  - age4: d=0 → FAIL D; d=1 → PASS D
- A failed attempt does not advance. An attempt finishing at age 4 retires.
- At most 4 events per cycle, from ages 4, 2, 1, 0. Enqueue order is oldest attempt first: age4, then age2, age1, age0.
- FIFO write: n events and free space f in the same cycle.
  - Write min(n,f) entries, oldest first.
  - Drop the remaining n−min(n,f) entries.
  - drop_cnt += dropped count (saturating); set ovf if any dropped.
- Free space counts a pop that happens in the same cycle.
- Pop: one entry when evt_valid && evt_ready.
- rst: clears all stage live bits, empties the FIFO, zeroes the stamp, clears ovf and drop_cnt. No verdict is produced for cleared attempts.

## Timing
- Reset values: evt_valid=0, evt_stamp=0, evt_pass=0, evt_code=0, level=0, ovf=0, drop_cnt=0.
- Verdict latency: a verdict decided at edge E is visible on evt_* in the cycle after E, if the FIFO was empty.
- Push and pop in the same cycle are legal. level updates by pushed−popped.
- evt_* hold stable while evt_valid=1 && evt_ready=0.
- Full FIFO with evt_ready=1: the popped slot is reusable in the same cycle, so no drop occurs for one event.
- Stamp wrap: stamps are raw counter values; no special handling at wrap.
- en=0: no new attempt starts, and no FAIL A is produced for that cycle.

## Structure
- Package seq_chk_pkg holds:
  - enum sig_code_e {CODE_A, CODE_B, CODE_C, CODE_D}.
  - packed struct evt_t {stamp, pass, code}, parameterized via STAMP_W localparam default.
  - localparam N_STAGES=5 and MAX_EVT=4.
- Sub-module seq_evt_fifo: multi-write (≤MAX_EVT), single-read FIFO over evt_t, with drop accounting. The top module holds the stamp counter, stage registers and check logic.

## Test plan
- Basic pass (REPORT_PASS=1, en=1): cycles 0..4 drive a=1@0, b=1@1, c=1@2, d=1@4, all else 0 → queue FAIL A stamps 1,2,3, then PASS D stamp 0, then FAIL A stamp 4. Stamp 0 is ordered before stamp 4 because both are decided in cycle 4.
- Quad event: a=1@0,2,3; b=1@1,3; c=1@2; cycle 4 all 0 → cycle 4 enqueues, in order, FAIL D stamp0, FAIL C stamp2, FAIL B stamp3, FAIL A stamp4; level +4.
- Overflow (DEPTH=4, evt_ready=0, a=0, en=1): entries stamps 0..3 kept; from cycle 4, ovf=1 and drop_cnt increments once per cycle; drop_cnt sticks at 255.
- Backpressure: toggle evt_ready each cycle → no loss while level<DEPTH; head fields stable while stalled; stamps dequeue in strictly increasing enqueue order.
- en gating: en=0 for cycles 5..9 with a=0 → no FAIL A for stamps 5..9; attempts started before cycle 5 still produce their verdicts.
- Reset mid-flight: assert rst at cycle 3 during a live a/b/c sequence → next cycle level=0, evt_valid=0, stamp=0; no verdict ever appears for pre-reset stamps.
